param_mem: RTL
==============

Name: param_mem

Overview:
- Parametrised single-port register-array memory; next generation of the 4x8 memory DUT driven through mem_intf.
- Adds generic address and data width, per-byte write strobes, and configurable read latency with a rd_valid qualifier.
- Adds protocol-error flagging and a hardware clear engine with a busy indication.
- Sits behind the bench driver/monitor as the DUT; also usable as a small scratchpad in larger blocks.

Parameters:
- ADDR_WIDTH, 2: address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8: word width; must be a multiple of 8.
- RD_LATENCY, 1: edges from read accept to rdata valid; legal range 1..3, checked at elaboration.
- INIT_VALUE, 0: DATA_WIDTH-bit word written to every location by the clear engine.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  ADDR_WIDTH  read/write word address.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- wdata  input  DATA_WIDTH  write data.
- wstrb  input  DATA_WIDTH/8  byte write enables; bit i covers wdata[8i+7:8i].
- clr_req  input  1  start clear of the whole array.
- rdata  output  DATA_WIDTH  read data.
- rd_valid  output  1  one-cycle pulse; rdata valid for this read.
- busy  output  1  clear engine active.
- err  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (reset=0, asynchronous): rdata=0, rd_valid=0, busy=0, err=0, FSM=IDLE, clear counter=0, read pipeline flushed. Array contents are not reset and are undefined until written or cleared.
- All requests are sampled at the rising edge of clk.
- Accepted write: IDLE, wr_en=1, rd_en=0, clr_req=0.
  - Each byte with wstrb[i]=1 is updated at that edge; other bytes keep their value.
  - wstrb=0 is legal: no update, no err.
- Accepted read: IDLE, rd_en=1, wr_en=0, clr_req=0.
  - Array is sampled at the accept edge, so the old value is returned.
  - rdata and rd_valid appear RD_LATENCY edges after accept; with RD_LATENCY=1 they are visible in the cycle after accept.
  - rdata holds its last value when rd_valid=0.
  - Back-to-back reads every cycle are supported; throughput is 1 per cycle.
  - A read one cycle after a write to the same address returns the new data.
- wr_en=1 and rd_en=1 together: neither is performed; err pulses on the next cycle.
- FSM states:
  - IDLE: clr_req=1 -> CLEAR, counter=0, busy=1 from the next cycle.
  - CLEAR: writes INIT_VALUE to location counter each cycle, counter increments. After writing DEPTH-1 -> IDLE, busy=0. busy is high for exactly DEPTH cycles.
- clr_req in the same cycle as wr_en or rd_en: clear wins, the request is dropped, err pulses.
- clr_req while busy: ignored, no err, clear is not restarted.
- wr_en or rd_en while busy: ignored, err pulses for each such cycle.
- Reads already in the pipeline when clear starts complete normally with pre-clear data.
- Reset mid-clear: the clear aborts, busy=0, contents are partially cleared and undefined.
- Address wraps naturally at ADDR_WIDTH bits; no out-of-range case exists.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, CLEAR}.
  - RD_LATENCY_MIN=1 and RD_LATENCY_MAX=3.
  - Helper function computing strobe width (DATA_WIDTH/8).
- One sub-module, mem_rd_pipe: a RD_LATENCY-deep delay line for {valid, data} with async active-low reset clearing valid and data to 0.
- Array, write-strobe logic and clear FSM live in param_mem.

Test Plan:
- Reset then basic write/read, defaults: write addr=2, wdata=8'hA5, wstrb=1 -> read addr=2 gives rdata=8'hA5 with rd_valid one cycle after accept; err stays 0.
- Byte strobes, DATA_WIDTH=32:
  - write addr=1, 32'h11223344, wstrb=4'hF.
  - then write 32'hAABBCCDD, wstrb=4'b0101.
  - read -> 32'h11BB33DD.
- Read latency, RD_LATENCY=3: four back-to-back reads of addrs 0..3 preloaded with 8'h10..8'h13 -> rd_valid high 4 consecutive cycles, first one 3 edges after first accept, data 8'h10,8'h11,8'h12,8'h13 in order.
- Collision: wr_en=rd_en=1 at addr=0 preloaded with 8'h55, wdata=8'hFF -> err single pulse, no rd_valid, later read returns 8'h55.
- Clear, INIT_VALUE=8'h3C, ADDR_WIDTH=2:
  - clr_req pulse -> busy high exactly 4 cycles.
  - wr_en during busy -> err pulse, write dropped.
  - all 4 reads after busy falls return 8'h3C.
- Reset mid-clear: drop reset on cycle 2 of CLEAR -> busy, rd_valid, err, rdata all 0 immediately (asynchronously); after release a new clr_req completes normally in 4 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the param_mem register-array memory.
package mem_pkg;

  // Clear engine state: IDLE serves requests, CLEAR sweeps the array.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 3;

  // Number of byte strobes covering one data word.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-data delay line: LATENCY register stages carrying {valid, data}.
// Data in a stage only loads alongside a valid beat, so the output data
// holds its last read value whenever out_valid is low.
module mem_rd_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q [LATENCY];
  logic [WIDTH-1:0] data_q  [LATENCY];

  // Shift valid every cycle; advance data only with a valid beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/param_mem.sv
// Parametrised single-port register-array memory with byte strobes,
// configurable read latency, protocol-error pulse and a clear engine.
//
// Request semantics: requests are level-sampled at each rising edge; there
// is no ready. In IDLE exactly one of wr_en / rd_en / clr_req is accepted.
// clr_req beats wr_en/rd_en (the other request is dropped, err pulses);
// wr_en with rd_en performs nothing and pulses err. While busy, wr_en/rd_en
// are dropped with err, clr_req is silently ignored. err and rd_valid are
// single-cycle pulses; rd_valid follows the accept edge by the pipeline
// depth (the accept edge loads the first stage).
module param_mem
  import mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic                              wr_en,
  input  logic                              rd_en,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [strb_width(DATA_WIDTH)-1:0] wstrb,
  input  logic                              clr_req,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              rd_valid,
  output logic                              busy,
  output logic                              err,
  output state_e                            state_dbg
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int STRB_W = strb_width(DATA_WIDTH);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_lat_check
    $error("param_mem: RD_LATENCY must lie in 1..3");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_width_check
    $error("param_mem: DATA_WIDTH must be a multiple of 8");
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic                    err_q;
  logic                    idle;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    clr_start;
  logic                    clr_last;
  logic                    err_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  assign idle      = (state_q == IDLE);
  assign clr_start = idle & clr_req;
  assign wr_acc    = idle & wr_en & ~rd_en & ~clr_req;
  assign rd_acc    = idle & rd_en & ~wr_en & ~clr_req;
  assign clr_last  = (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1));

  // Rejected request: collision, clear pre-empting a request, or busy.
  assign err_d = idle ? ((clr_req & (wr_en | rd_en)) | (wr_en & rd_en))
                      : (wr_en | rd_en);

  // Next-state logic for the clear engine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req)  state_d = CLEAR;
      CLEAR:   if (clr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: FSM state, clear address counter, error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (clr_start)               clr_cnt_q <= '0;
      else if (state_q == CLEAR)   clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  // Array update: clear sweep has priority, otherwise strobed byte writes.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= INIT_VALUE;
    end else if (wr_acc) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Array is sampled at the accept edge, so a read returns the pre-edge value.
  mem_rd_pipe #(
    .LATENCY (RD_LATENCY),
    .WIDTH   (DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_acc),
    .in_data   (mem_q[addr]),
    .out_valid (rd_valid),
    .out_data  (rdata)
  );

  assign busy      = (state_q == CLEAR);
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule
